ccg_truth_table_sweeper: RTL

Sequencer that exhaustively drives every input vector of a generated combinational circuit (N_IN inputs x*, N_OUT outputs f*) and streams the resulting truth-table rows out over a valid/ready interface. It sits between the characterisation harness and the circuit under test, which is an instantiated CCGRCG-style netlist. It also holds a running signature so a whole sweep can be compared against a golden value. The block owns sequencing only. It contains no knowledge of the circuit function.

---
 rtl/ccg_truth_table_sweeper.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ccg_truth_table_sweeper.sv
// Exhaustive input sweeper for a generated combinational circuit; streams truth-table rows.
// Optional MISR signature over accepted rows is enabled by defining CCG_SWEEP_MISR_EN.
module ccg_truth_table_sweeper #(
  parameter int N_IN   = 6,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [N_IN-1:0]  x_out,
  input  logic [N_OUT-1:0] f_in,
  output logic             tt_valid,
  input  logic             tt_ready,
  output logic [N_IN-1:0]  tt_addr,
  output logic [N_OUT-1:0] tt_data,
  output logic             busy,
  output logic             done,
  output logic [15:0]      signature
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N_IN-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_OUT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [N_IN-1:0]  idx_q, idx_d;
  logic [CW-1:0]    settle_q, settle_d;
  logic [N_IN-1:0]  addr_q;
  logic [N_OUT-1:0] data_q;
  logic             capture;
  logic             accept;

  assign accept = tt_valid & tt_ready;

  // NOTE: sequential state uses nonblocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    capture  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_APPLY;
          idx_d    = '0;
          settle_d = '0;
        end
      end
      S_APPLY: begin
        if (settle_q == CW'(SETTLE - 1)) begin
          capture = 1'b1;
          state_d = S_OUT;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_OUT: begin
        // Completion is a compare on the last index, never a wrap of idx.
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d    = idx_q + 1'b1;
            settle_d = '0;
            state_d  = S_APPLY;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Row register: sampled once per vector, after the settle window, and held through OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (capture) begin
      addr_q <= idx_q;
      data_q <= f_in;
    end
  end

  assign x_out    = (state_q == S_APPLY || state_q == S_OUT) ? idx_q : '0;
  assign tt_valid = (state_q == S_OUT);
  assign tt_addr  = addr_q;
  assign tt_data  = data_q;
  assign busy     = (state_q == S_APPLY) || (state_q == S_OUT);
  assign done     = (state_q == S_DONE);

`ifdef CCG_SWEEP_MISR_EN
  logic [15:0] sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 16'h0000;
    end else if (state_q == S_IDLE && start) begin
      sig_q <= 16'h0000;
    end else if (accept) begin
      sig_q <= {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000) ^ 16'(data_q);
    end
  end

  assign signature = sig_q;
`else
  assign signature = 16'h0000;
`endif

endmodule
